// File: rtl/pipe_adder.sv
// ============================================================================
// pipe_adder : pipelined add/subtract, one SEG-bit slice per stage, with a
//              valid/ready handshake on both sides.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SEG;

  function automatic logic [SEG:0] slice_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  logic                adv;
  logic [WIDTH-1:0]    b_eff;
  logic                c0;

  logic [STAGES:1]     v_q, v_d;
  logic [STAGES:1]     c_q, c_d;
  logic                ov_q, ov_d;
  logic [WIDTH-1:0]    a_q [1:STAGES];
  logic [WIDTH-1:0]    a_d [1:STAGES];
  logic [WIDTH-1:0]    b_q [1:STAGES];
  logic [WIDTH-1:0]    b_d [1:STAGES];
  logic [WIDTH-1:0]    s_q [1:STAGES];
  logic [WIDTH-1:0]    s_d [1:STAGES];
  logic [SEG:0]        slice_r [1:STAGES];

  assign adv   = !v_q[STAGES] || out_ready;
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  // Stage k's slice result: stage 1 works on the live inputs, later stages on
  // the operands and carry held by the preceding stage.
  always_comb begin
    slice_r[1] = slice_add(a[SEG-1:0], b_eff[SEG-1:0], c0);
    for (int k = 2; k <= STAGES; k++) begin
      slice_r[k] = slice_add(a_q[k-1][(k-1)*SEG +: SEG],
                             b_q[k-1][(k-1)*SEG +: SEG],
                             c_q[k-1]);
    end
  end

  always_comb begin
    v_d  = v_q;
    c_d  = c_q;
    ov_d = ov_q;
    a_d  = a_q;
    b_d  = b_q;
    s_d  = s_q;
    if (adv) begin
      v_d[1]            = in_valid;
      a_d[1]            = a;
      b_d[1]            = b_eff;
      s_d[1]            = '0;
      s_d[1][SEG-1:0]   = slice_r[1][SEG-1:0];
      c_d[1]            = slice_r[1][SEG];
      for (int k = 2; k <= STAGES; k++) begin
        v_d[k]                      = v_q[k-1];
        a_d[k]                      = a_q[k-1];
        b_d[k]                      = b_q[k-1];
        s_d[k]                      = s_q[k-1];
        s_d[k][(k-1)*SEG +: SEG]    = slice_r[k][SEG-1:0];
        c_d[k]                      = slice_r[k][SEG];
      end
      // Overflow is judged on the operands entering the last stage.
      ov_d = (a_d[STAGES][WIDTH-1] == b_d[STAGES][WIDTH-1]) &&
             (s_d[STAGES][WIDTH-1] != a_d[STAGES][WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q  <= '0;
      c_q  <= '0;
      ov_q <= 1'b0;
      a_q  <= '{default: '0};
      b_q  <= '{default: '0};
      s_q  <= '{default: '0};
    end else begin
      v_q  <= v_d;
      c_q  <= c_d;
      ov_q <= ov_d;
      a_q  <= a_d;
      b_q  <= b_d;
      s_q  <= s_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[STAGES];
  assign sum       = s_q[STAGES];
  assign carry     = c_q[STAGES];
  assign overflow  = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// ============================================================================
// tb_pipe_adder : directed and randomised checks of pipe_adder (16-bit, 4 stages)
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_adder;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              carry;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {sum, carry, overflow}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] be;
    logic [16:0] r;
    logic        ov;
    be = sb ? ~y : y;
    r  = {1'b0, x} + {1'b0, be} + {16'd0, sb | ci};
    ov = (x[15] == be[15]) && (r[15] != x[15]);
    return {r[15:0], r[16], ov};
  endfunction

  // Offers one beat at a falling edge; result must show up on the 4th falling
  // edge after that, not the 3rd.
  task automatic run_one(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xc, input logic xs,
                         input logic [15:0] esum, input logic ec, input logic eov);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_early_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sum"}, 32'(sum), 32'(esum));
    chk({tag, "_carry"}, 32'(carry), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0] q[$];
    logic [17:0] exp_r;
    int          exp_idx;
    int          nxt;
    int          accepted;
    int          cyc;
    bit          did_rst;

    // Reset held with a beat offered: nothing may survive it.
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("rst_no_beat", 32'(out_valid), 0);
    end
    @(negedge clk);

    run_one("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_one("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run_one("add_xslice",  16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_one("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: consumer stalls during cycles 5..9 of an 8-beat stream.
    exp_idx = 0;
    nxt     = 0;
    for (int t = 0; t < 40 && exp_idx < 8; t++) begin
      out_ready = !(t >= 5 && t <= 9);
      in_valid  = (nxt < 8);
      a = 16'(nxt); b = 16'(nxt); cin = 1'b0; sub = 1'b0;
      #1;
      chk("bp_in_ready", 32'(in_ready), (t >= 5 && t <= 9) ? 0 : 1);
      if (out_valid) begin
        chk("bp_sum", 32'(sum), 32'(2 * exp_idx));
        if (out_ready) exp_idx++;
      end
      if (in_valid && in_ready) nxt++;
      @(negedge clk);
    end
    chk("bp_delivered", exp_idx, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("bp_no_extra", 32'(out_valid), 0);
      @(negedge clk);
    end

    // Random traffic with one reset pulse midway.
    accepted = 0;
    cyc      = 0;
    did_rst  = 1'b0;
    while (accepted < 1000 && cyc < 20000) begin
      cyc++;
      if (!did_rst && accepted >= 500) begin
        rst_n     = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        did_rst   = 1'b1;
        q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rnd_rst_out_valid", 32'(out_valid), 0);
        chk("rnd_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        continue;
      end
      in_valid  = 1'($urandom_range(0, 1));
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk("rnd_queue_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          chk("rnd_beat", 32'({sum, carry, overflow}), 32'(exp_r));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        accepted++;
      end
      @(negedge clk);
    end
    chk("rnd_all_offered", accepted, 1000);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (out_valid) begin
        chk("rnd_drain_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          chk("rnd_drain_beat", 32'({sum, carry, overflow}), 32'(exp_r));
        end
      end
      @(negedge clk);
    end
    chk("rnd_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
